// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD min:sec.cs stopwatch on a toggling 10 ms tick line; define STOPWATCH_HOURS_EN to add an hours field
module stopwatch_counter #(
  parameter int CS_MAX = 99,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_base_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_timerenb,
  output logic       o_running,
  output logic       o_lap_active,
  output logic [7:0] o_cs,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
`ifdef STOPWATCH_HOURS_EN
  output logic [7:0] o_hr,
`endif
  output logic       o_rollover
);
`ifdef STOPWATCH_HOURS_EN
  localparam int TW = 32;
`else
  localparam int TW = 24;
`endif
  localparam logic [7:0] CS_LIM = 8'(((CS_MAX / 10) << 4) | (CS_MAX % 10));
  localparam logic [7:0] SEC_LIM = 8'(((SEC_MAX / 10) << 4) | (SEC_MAX % 10));
  localparam logic [7:0] MIN_LIM = 8'(((MIN_MAX / 10) << 4) | (MIN_MAX % 10));
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
  state_t state_q, state_d;
  logic tick_q, tick_evt, counting, count_en, wrap, roll_d;
  logic [8:0] c, s, m;
`ifdef STOPWATCH_HOURS_EN
  logic [8:0] h;
`endif
  logic [TW-1:0] live_q, latch_q, disp_q, inc, live_d, latch_d, disp_d;
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v == lim) ? 9'h100 :
           (v[3:0] == 4'd9) ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction
  always_comb begin
    counting = state_q == RUN || state_q == LAP;
    tick_evt = i_base_tick ^ tick_q;
    count_en = tick_evt && counting && !i_clear;
    c = bcd_inc(live_q[7:0], CS_LIM);
    s = bcd_inc(live_q[15:8], SEC_LIM);
    m = bcd_inc(live_q[23:16], MIN_LIM);
    inc = live_q;
    inc[7:0] = c[7:0];
    inc[15:8] = c[8] ? s[7:0] : live_q[15:8];
    inc[23:16] = (c[8] && s[8]) ? m[7:0] : live_q[23:16];
    wrap = c[8] && s[8] && m[8];
`ifdef STOPWATCH_HOURS_EN
    h = bcd_inc(live_q[31:24], 8'h99);
    inc[31:24] = wrap ? h[7:0] : live_q[31:24];
    wrap = wrap && h[8];
`endif
    state_d = i_clear ? IDLE :
              i_start_stop ? (counting ? PAUSE : RUN) :
              (i_lap && state_q == RUN) ? LAP :
              (i_lap && state_q == LAP) ? RUN : state_q;
    latch_d = i_clear ? '0 : (!i_start_stop && i_lap && state_q == RUN) ? live_q : latch_q;
    live_d = i_clear ? '0 : count_en ? inc : live_q;
    roll_d = count_en && wrap;
    disp_d = (state_d == LAP) ? latch_d : live_d;
  end
  always_ff @(posedge i_sclk) begin
    tick_q <= i_base_tick;
    if (!i_reset_n) begin
      state_q <= IDLE;
      live_q <= '0;
      latch_q <= '0;
      disp_q <= '0;
      o_rollover <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= live_d;
      latch_q <= latch_d;
      disp_q <= disp_d;
      o_rollover <= roll_d;
    end
  end
  assign o_running = state_q == RUN || state_q == LAP;
  assign o_lap_active = state_q == LAP;
  assign o_timerenb = o_running;
  assign o_cs = disp_q[7:0];
  assign o_sec = disp_q[15:8];
  assign o_min = disp_q[23:16];
`ifdef STOPWATCH_HOURS_EN
  assign o_hr = disp_q[31:24];
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: scoreboard bench using an integer-centisecond reference model
module tb_stopwatch_counter;
  localparam int CS = 99;
  localparam int SEC = 59;
  localparam int MIN = 2;
`ifdef STOPWATCH_HOURS_EN
  localparam int MAXC = (CS + 1) * (SEC + 1) * (MIN + 1) * 100;
`else
  localparam int MAXC = (CS + 1) * (SEC + 1) * (MIN + 1);
`endif
  typedef struct packed {
    logic [31:0] disp;
    logic run;
    logic lapa;
    logic roll;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0, base = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic timerenb, running, lap_active, rollover;
  logic [7:0] cs, sec, mn, hr;
  logic [31:0] disp;
  exp_t q[$];
  int checks = 0, errors = 0;
  int st = 0, live = 0, latch = 0, rolls = 0;
  bit roll = 0;
  always #5 clk = ~clk;
  stopwatch_counter #(.CS_MAX(CS), .SEC_MAX(SEC), .MIN_MAX(MIN)) dut (
    .i_sclk(clk), .i_reset_n(reset_n), .i_base_tick(base), .i_start_stop(start_stop),
    .i_clear(clear), .i_lap(lap), .o_timerenb(timerenb), .o_running(running),
    .o_lap_active(lap_active), .o_cs(cs), .o_sec(sec), .o_min(mn),
`ifdef STOPWATCH_HOURS_EN
    .o_hr(hr),
`endif
    .o_rollover(rollover)
  );
`ifndef STOPWATCH_HOURS_EN
  assign hr = 8'h00;
`endif
  assign disp = {hr, mn, sec, cs};
  function automatic logic [7:0] b2(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  function automatic logic [31:0] tobcd(input int t);
    int r;
    logic [31:0] v;
    v[7:0] = b2(t % (CS + 1));
    r = t / (CS + 1);
    v[15:8] = b2(r % (SEC + 1));
    r = r / (SEC + 1);
    v[23:16] = b2(r % (MIN + 1));
    v[31:24] = b2((r / (MIN + 1)) % 100);
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic step(input bit rn, input bit ss, input bit clr, input bit lp, input bit tk);
    exp_t e, g;
    bit cnt;
    int old;
    @(negedge clk);
    reset_n = rn; start_stop = ss; clear = clr; lap = lp;
    if (tk) base = ~base;
    cnt = st == 1 || st == 3;
    old = live;
    roll = 0;
    if (!rn || clr) begin
      st = 0; live = 0; latch = 0;
    end else begin
      if (cnt && tk) begin
        live++;
        if (live == MAXC) begin live = 0; roll = 1; end
      end
      if (ss) st = cnt ? 2 : 1;
      else if (lp && st == 1) begin latch = old; st = 3; end
      else if (lp && st == 3) st = 1;
    end
    e.disp = tobcd(st == 3 ? latch : live);
    e.run = st == 1 || st == 3;
    e.lapa = st == 3;
    e.roll = roll;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("disp", disp, g.disp);
    chk("running", 32'(running), 32'(g.run));
    chk("timerenb", 32'(timerenb), 32'(g.run));
    chk("lap_active", 32'(lap_active), 32'(g.lapa));
    chk("rollover", 32'(rollover), 32'(g.roll));
    if (rollover) rolls++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1);
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("reset_disp", disp, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);
    chk("idle_disp", disp, 32'h0);
    step(1, 1, 0, 0, 0);
    run(100);
    chk("one_sec", disp, 32'h0000_0100);
    run(MAXC - 102);
    rolls = 0;
    run(2);
    run(3);
`ifdef STOPWATCH_HOURS_EN
    chk("no_roll", 32'(rolls), 32'd0);
`else
    chk("one_roll", 32'(rolls), 32'd1);
`endif
    step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    run(307);
    step(1, 0, 0, 1, 0);
    run(50);
    chk("lap_hold", disp, 32'h0000_0307);
    step(1, 0, 0, 1, 0);
    chk("lap_release", disp, 32'h0000_0357);
    step(1, 0, 0, 1, 1);
    run(5);
    step(1, 1, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1);
    run(42);
    step(1, 1, 0, 0, 1);
    run(10);
    chk("pause_hold", disp, 32'h0000_0043);
    chk("pause_tenb", 32'(timerenb), 32'd0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 0);
    run(1234);
    step(1, 1, 1, 0, 1);
    chk("clear_prio", disp, 32'h0);
    run(3);
    step(1, 1, 0, 0, 0);
    run(20);
    step(0, 0, 0, 0, 1);
    chk("mid_reset", disp, 32'h0);
    run(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
